dbus_uart_bridge: RTL and testbench
===================================

// Module: dbus_uart_bridge
// PURPOSE
// - Debug bus initiator: decodes a byte-stream command protocol (from the UART byte receiver) into
//   single-word VexRiscv-style dBus transactions and returns status/read data as a byte stream.
// - Shares the RAM/IO dBus port with the CPU through an external arbiter; peeks/pokes RAM and IO regs.
// PARAMETERS
// - CLK_FREQ      100000000  clock frequency in Hz; scales the inter-byte timeout
// - RISCV_WL      32         bus data/address width; only 32 supported
// - TIMEOUT_MS    10         inter-byte frame timeout in ms (used only with DBUS_BRIDGE_TIMEOUT_EN)
// PORTS
// - clk                      in   1   system clock
// - reset                    in   1   synchronous, active-high reset
// - rx_valid                 in   1   rx_data holds a received byte this cycle (single-cycle pulse, no backpressure)
// - rx_data                  in   8   received byte
// - tx_valid                 out  1   tx_data holds a byte to send
// - tx_ready                 in   1   byte sink accepts tx_data when tx_valid&&tx_ready
// - tx_data                  out  8   byte to transmit
// - dBus_cmd_valid           out  1   bus command request
// - dBus_cmd_ready           in   1   command accepted when valid&&ready
// - dBus_cmd_payload_wr      out  1   1=write, 0=read
// - dBus_cmd_payload_address out  32  byte address, bits[1:0] forced to 0
// - dBus_cmd_payload_data    out  32  write data
// - dBus_cmd_payload_size    out  2   always 2'b10 (word)
// - dBus_rsp_ready           in   1   read response valid (reads only; writes produce none)
// - dBus_rsp_error           in   1   read response error, sampled with dBus_rsp_ready
// - dBus_rsp_data            in   32  read data, sampled with dBus_rsp_ready
// - busy                     out 1   high in any state other than IDLE
// BEHAVIOUR
// - Frame: opcode, ADDR[7:0..31:24] LSB first; opcode 0x57 'W' adds DATA LSB first (9 bytes); 0x52 'R' is 5 bytes.
// - Replies: read -> status + 4 data bytes LSB first; write -> status only. Status 0x06 ACK, 0x15 NAK (rsp_error).
// - Read with error still returns 4 data bytes (captured dBus_rsp_data). Writes always ACK.
// - FSM: IDLE -> ADDR(4 bytes) -> [DATA(4 bytes) if write] -> CMD -> [RSP_WAIT if read] -> TX_STAT -> [TX_DATA 4 bytes] -> IDLE.
// - IDLE: byte not 0x57/0x52 is discarded silently; no reply, stay IDLE.
// - 2-bit byte counter shared by ADDR/DATA/TX_DATA; wraps 3->0 on state exit.
// - CMD: dBus_cmd_valid asserted the cycle after last frame byte; all payload held stable until ready.
// - Write: CMD -> TX_STAT on handshake. Read: CMD -> RSP_WAIT; capture data/error on first rsp_ready.
// - rsp_ready arriving in the handshake cycle itself is ignored (rsp is >=1 cycle after cmd accept).
// - TX: tx_valid/tx_data held stable until tx_ready; next byte presented the cycle after accept.
// - rx_valid outside IDLE/ADDR/DATA (CMD, RSP_WAIT, TX_*) is dropped; no queuing.
// - Reset values: tx_valid=0, tx_data=0, dBus_cmd_valid=0, wr=0, address=0, data=0, busy=0; FSM IDLE.
// - reset mid-frame or mid-transaction: abort immediately, no reply; an in-flight bus read response is discarded.
// CONFIGURATION
// - DBUS_BRIDGE_TIMEOUT_EN defined: counter of CLK_FREQ/1000*TIMEOUT_MS cycles runs in ADDR/DATA,
//   cleared on each rx_valid; on expiry drop partial frame -> IDLE, no bus cycle, no reply.
//   Also in RSP_WAIT: on expiry send NAK then 4 bytes 0x00.
// - Not defined: no timeout logic; a partial frame waits indefinitely; RSP_WAIT waits indefinitely.
// TESTING
// - Read: rx 52 00 00 00 80, bus rsp data=0x0000000A err=0 -> cmd addr=0x80000000 wr=0; tx 06 0A 00 00 00.
// - Write: rx 57 0C 00 00 80 F0 00 00 00 -> one cmd wr=1 addr=0x8000000C data=0x000000F0 size=2; tx 06.
// - Error: read addr 0x00010000 with rsp_error=1 data=0xDEADBEEF -> tx 15 EF BE AD DE.
// - Backpressure: cmd_ready low 5 cycles, tx_ready toggling -> payload/tx_data stable, no byte lost or duplicated.
// - Junk/unaligned: rx 41 then read addr 0x00000003 -> 0x41 ignored; cmd address 0x00000000.
// - Timeout (macro on, TIMEOUT_MS=1 @100MHz): rx 52 00, idle 100000 cycles -> IDLE, no cmd, no tx; next frame ok.

Source files
------------

// File: rtl/dbus_uart_bridge.sv
// ---------------------------------------------------------------------------
// dbus_uart_bridge
//
// Debug bus initiator.
// - Turns a byte-stream command protocol from a UART receiver into single-word
//   dBus transactions.
// - Returns the status and any read data as a byte stream.
// - Shares the RAM/IO dBus port with the CPU through an external arbiter.
//
// Frames (multi-byte fields are LSB first):
//   'R' (0x52) ADDR[4]          -> reply: status, DATA[4]
//   'W' (0x57) ADDR[4] DATA[4]  -> reply: status
//   Status is 0x06 (ACK), or 0x15 (NAK) when a read returns rsp_error.
//   Bytes other than 'R'/'W' seen while idle are discarded without a reply.
//
// Optional feature, macro DBUS_BRIDGE_TIMEOUT_EN:
//   An inter-byte timeout of CLK_FREQ/1000*TIMEOUT_MS cycles.
//   - A partial frame that stalls is dropped silently.
//   - A read response that never arrives produces NAK followed by 00 00 00 00.
//   Without the macro the bridge waits indefinitely in both places.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   rx_valid, rx_data           received byte (single-cycle pulse, no backpressure)
//   tx_valid, tx_ready, tx_data byte output, valid/ready handshake
//   dBus_cmd_*                  bus command (valid/ready, wr, address, data, size)
//   dBus_rsp_*                  read response (ready strobe, error, data)
//   busy                        high whenever the bridge is not idle
// ---------------------------------------------------------------------------
module dbus_uart_bridge #(
    parameter int CLK_FREQ   = 100000000,
    parameter int RISCV_WL   = 32,
    parameter int TIMEOUT_MS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                dBus_cmd_valid,
    input  logic                dBus_cmd_ready,
    output logic                dBus_cmd_payload_wr,
    output logic [RISCV_WL-1:0] dBus_cmd_payload_address,
    output logic [RISCV_WL-1:0] dBus_cmd_payload_data,
    output logic [1:0]          dBus_cmd_payload_size,
    input  logic                dBus_rsp_ready,
    input  logic                dBus_rsp_error,
    input  logic [RISCV_WL-1:0] dBus_rsp_data,
    output logic                busy
);

    // Elaboration-time guards on the configuration.
    if (RISCV_WL != 32) begin : g_bad_wl
        $error("dbus_uart_bridge: only RISCV_WL=32 is supported");
    end
    if ((CLK_FREQ / 1000) * TIMEOUT_MS < 1) begin : g_bad_timeout
        $error("dbus_uart_bridge: timeout must be at least one cycle");
    end

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ST_ACK   = 8'h06;
    localparam logic [7:0] ST_NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_DATA     = 3'd2,
        S_CMD      = 3'd3,
        S_RSP_WAIT = 3'd4,
        S_TX_STAT  = 3'd5,
        S_TX_DATA  = 3'd6
    } state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;      // byte index shared by ADDR, DATA and TX_DATA
    logic [1:0]  cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        wr_q;
    logic        cmd_valid_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;

`ifdef DBUS_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = (CLK_FREQ / 1000) * TIMEOUT_MS;
    localparam logic [31:0] TO_LAST   = 32'(TO_CYCLES - 1);
    logic [31:0] timer_q;
    logic        timeout_s;
    assign timeout_s = (timer_q == TO_LAST);
`endif

    // The counter wraps 3 -> 0 by itself, so it is already 0 when a phase ends.
    assign cnt_d = cnt_q + 2'd1;

    assign busy                     = (state_q != S_IDLE);
    assign tx_valid                 = tx_valid_q;
    assign tx_data                  = tx_data_q;
    assign dBus_cmd_valid           = cmd_valid_q;
    assign dBus_cmd_payload_wr      = wr_q;
    assign dBus_cmd_payload_address = {addr_q[31:2], 2'b00};
    assign dBus_cmd_payload_data    = wdata_q;
    assign dBus_cmd_payload_size    = 2'b10;

    // Protocol FSM: frame decode, bus command/response, reply transmit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            wr_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
`ifdef DBUS_BRIDGE_TIMEOUT_EN
            timer_q     <= 32'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= 2'd0;
`ifdef DBUS_BRIDGE_TIMEOUT_EN
                    timer_q <= 32'd0;
`endif
                    if (rx_valid && (rx_data == OP_WRITE)) begin
                        wr_q    <= 1'b1;
                        state_q <= S_ADDR;
                    end else if (rx_valid && (rx_data == OP_READ)) begin
                        wr_q    <= 1'b0;
                        state_q <= S_ADDR;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_ADDR: begin
                    if (rx_valid) begin
                        addr_q[{cnt_q, 3'b000} +: 8] <= rx_data;
                        cnt_q <= cnt_d;
`ifdef DBUS_BRIDGE_TIMEOUT_EN
                        timer_q <= 32'd0;
`endif
                        if (cnt_q == 2'd3) begin
                            if (wr_q) begin
                                state_q <= S_DATA;
                            end else begin
                                state_q     <= S_CMD;
                                cmd_valid_q <= 1'b1;
                            end
                        end
`ifdef DBUS_BRIDGE_TIMEOUT_EN
                    end else if (timeout_s) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 2'd0;
                    end else begin
                        timer_q <= timer_q + 32'd1;
`else
                    end else begin
                        state_q <= S_ADDR;
`endif
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        wdata_q[{cnt_q, 3'b000} +: 8] <= rx_data;
                        cnt_q <= cnt_d;
`ifdef DBUS_BRIDGE_TIMEOUT_EN
                        timer_q <= 32'd0;
`endif
                        if (cnt_q == 2'd3) begin
                            state_q     <= S_CMD;
                            cmd_valid_q <= 1'b1;
                        end
`ifdef DBUS_BRIDGE_TIMEOUT_EN
                    end else if (timeout_s) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 2'd0;
                    end else begin
                        timer_q <= timer_q + 32'd1;
`else
                    end else begin
                        state_q <= S_DATA;
`endif
                    end
                end

                // Payload registers are untouched here, so they stay stable until ready.
                S_CMD: begin
                    if (dBus_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
`ifdef DBUS_BRIDGE_TIMEOUT_EN
                        timer_q <= 32'd0;
`endif
                        if (wr_q) begin
                            state_q    <= S_TX_STAT;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= ST_ACK;
                        end else begin
                            state_q <= S_RSP_WAIT;
                        end
                    end else begin
                        state_q <= S_CMD;
                    end
                end

                // A response strobe in the accept cycle itself is seen in S_CMD and ignored.
                S_RSP_WAIT: begin
                    if (dBus_rsp_ready) begin
                        rdata_q    <= dBus_rsp_data;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= dBus_rsp_error ? ST_NAK : ST_ACK;
                        state_q    <= S_TX_STAT;
`ifdef DBUS_BRIDGE_TIMEOUT_EN
                    end else if (timeout_s) begin
                        rdata_q    <= 32'd0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ST_NAK;
                        state_q    <= S_TX_STAT;
                    end else begin
                        timer_q <= timer_q + 32'd1;
`else
                    end else begin
                        state_q <= S_RSP_WAIT;
`endif
                    end
                end

                S_TX_STAT: begin
                    if (tx_ready) begin
                        if (wr_q) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            tx_data_q <= rdata_q[7:0];
                            cnt_q     <= 2'd0;
                            state_q   <= S_TX_DATA;
                        end
                    end else begin
                        state_q <= S_TX_STAT;
                    end
                end

                S_TX_DATA: begin
                    if (tx_ready) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            tx_data_q <= rdata_q[{cnt_d, 3'b000} +: 8];
                        end
                    end else begin
                        state_q <= S_TX_DATA;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= 2'd0;
                    cmd_valid_q <= 1'b0;
                    tx_valid_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_uart_bridge.sv
module tb_dbus_uart_bridge;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr;
    logic [31:0] dBus_cmd_payload_address;
    logic [31:0] dBus_cmd_payload_data;
    logic [1:0]  dBus_cmd_payload_size;
    logic        dBus_rsp_ready;
    logic        dBus_rsp_error;
    logic [31:0] dBus_rsp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dbus_uart_bridge dut (
        .clk                      (clk),
        .reset                    (reset),
        .rx_valid                 (rx_valid),
        .rx_data                  (rx_data),
        .tx_valid                 (tx_valid),
        .tx_ready                 (tx_ready),
        .tx_data                  (tx_data),
        .dBus_cmd_valid           (dBus_cmd_valid),
        .dBus_cmd_ready           (dBus_cmd_ready),
        .dBus_cmd_payload_wr      (dBus_cmd_payload_wr),
        .dBus_cmd_payload_address (dBus_cmd_payload_address),
        .dBus_cmd_payload_data    (dBus_cmd_payload_data),
        .dBus_cmd_payload_size    (dBus_cmd_payload_size),
        .dBus_rsp_ready           (dBus_rsp_ready),
        .dBus_rsp_error           (dBus_rsp_error),
        .dBus_rsp_data            (dBus_rsp_data),
        .busy                     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cmd_stall;
        int          tx_stall;
        logic [31:0] exp_addr;
        int          n_tx;
        logic [39:0] exp_tx;   // byte i of the reply in bits [8*i +: 8]
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // All stimulus changes happen at the falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] a;
        logic [31:0] d;
        a = addr;
        d = wdata;
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (op == 8'h57) begin
            for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        end
    endtask

    // Wait for the command, hold ready low for 'stall' cycles while checking stability, then accept.
    task automatic do_cmd(input logic exp_wr, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                          input int stall, input logic rsp_in_accept);
        int t;
        t = 0;
        while (!dBus_cmd_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_valid", {39'd0, dBus_cmd_valid}, 40'd1);
        for (int s = 0; s <= stall; s++) begin
            check("cmd_addr", {8'd0, dBus_cmd_payload_address}, {8'd0, exp_addr});
            check("cmd_wr", {39'd0, dBus_cmd_payload_wr}, {39'd0, exp_wr});
            check("cmd_size", {38'd0, dBus_cmd_payload_size}, 40'd2);
            if (exp_wr) check("cmd_data", {8'd0, dBus_cmd_payload_data}, {8'd0, exp_data});
            if (s < stall) begin
                check("cmd_hold_valid", {39'd0, dBus_cmd_valid}, 40'd1);
                @(negedge clk);
            end
        end
        dBus_cmd_ready = 1'b1;
        if (rsp_in_accept) begin
            dBus_rsp_ready = 1'b1;
            dBus_rsp_error = 1'b1;
            dBus_rsp_data  = 32'hBAD0BAD0;
        end
        @(negedge clk);
        dBus_cmd_ready = 1'b0;
        dBus_rsp_ready = 1'b0;
        dBus_rsp_error = 1'b0;
        dBus_rsp_data  = 32'h5A5A5A5A;
        check("cmd_dropped", {39'd0, dBus_cmd_valid}, 40'd0);
    endtask

    task automatic do_rsp(input int delay, input logic [31:0] data, input logic err);
        repeat (delay) @(negedge clk);
        dBus_rsp_ready = 1'b1;
        dBus_rsp_error = err;
        dBus_rsp_data  = data;
        @(negedge clk);
        dBus_rsp_ready = 1'b0;
        dBus_rsp_error = 1'b0;
        dBus_rsp_data  = 32'h5A5A5A5A;
    endtask

    // Collect n reply bytes, stalling tx_ready 'stall' cycles before each accept.
    task automatic collect_tx(input int n, input logic [39:0] exp, input int stall);
        int t;
        logic [39:0] e;
        e = exp;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!tx_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("tx_valid", {39'd0, tx_valid}, 40'd1);
            for (int s = 0; s < stall; s++) begin
                check("tx_hold", {32'd0, tx_data}, {32'd0, e[8*i +: 8]});
                @(negedge clk);
            end
            check("tx_data", {32'd0, tx_data}, {32'd0, e[8*i +: 8]});
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        check("tx_end", {39'd0, tx_valid}, 40'd0);
        check("busy_end", {39'd0, busy}, 40'd0);
    endtask

    initial begin
        vecs[0] = '{8'h52, 32'h80000000, 32'h0,        32'h0000000A, 1'b0, 0, 0, 32'h80000000, 5, 40'h000000_0A_06};
        vecs[1] = '{8'h57, 32'h8000000C, 32'h000000F0, 32'h0,        1'b0, 0, 0, 32'h8000000C, 1, 40'h00000000_06};
        vecs[2] = '{8'h52, 32'h00010000, 32'h0,        32'hDEADBEEF, 1'b1, 0, 0, 32'h00010000, 5, 40'hDEADBEEF_15};
        vecs[3] = '{8'h52, 32'h00000003, 32'h0,        32'h12345678, 1'b0, 5, 2, 32'h00000000, 5, 40'h12345678_06};
        vecs[4] = '{8'h57, 32'h1234567B, 32'hA5A55A5A, 32'h0,        1'b0, 5, 3, 32'h12345678, 1, 40'h00000000_06};
        vecs[5] = '{8'h52, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 1'b0, 1, 1, 32'hFFFFFFFC, 5, 40'hFFFFFFFF_06};

        reset          = 1'b1;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        tx_ready       = 1'b0;
        dBus_cmd_ready = 1'b0;
        dBus_rsp_ready = 1'b0;
        dBus_rsp_error = 1'b0;
        dBus_rsp_data  = 32'h5A5A5A5A;
        repeat (3) @(negedge clk);

        check("rst_tx_valid", {39'd0, tx_valid}, 40'd0);
        check("rst_tx_data", {32'd0, tx_data}, 40'd0);
        check("rst_cmd_valid", {39'd0, dBus_cmd_valid}, 40'd0);
        check("rst_wr", {39'd0, dBus_cmd_payload_wr}, 40'd0);
        check("rst_addr", {8'd0, dBus_cmd_payload_address}, 40'd0);
        check("rst_data", {8'd0, dBus_cmd_payload_data}, 40'd0);
        check("rst_busy", {39'd0, busy}, 40'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table of complete transactions.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            do_cmd(vecs[i].op == 8'h57, vecs[i].exp_addr, vecs[i].wdata, vecs[i].cmd_stall, 1'b0);
            if (vecs[i].op != 8'h57) do_rsp(2, vecs[i].rdata, vecs[i].err);
            collect_tx(vecs[i].n_tx, vecs[i].exp_tx, vecs[i].tx_stall);
        end

        // Junk bytes while idle: no state change, no reply.
        send_byte(8'h41);
        send_byte(8'h00);
        check("junk_busy", {39'd0, busy}, 40'd0);
        check("junk_tx", {39'd0, tx_valid}, 40'd0);
        send_frame(8'h52, 32'h00000003, 32'h0);
        do_cmd(1'b0, 32'h00000000, 32'h0, 0, 1'b0);
        do_rsp(1, 32'h00000041, 1'b0);
        collect_tx(5, 40'h00000041_06, 0);

        // Response strobe in the accept cycle is ignored; rx bytes during reply are dropped.
        send_frame(8'h52, 32'h00000100, 32'h0);
        do_cmd(1'b0, 32'h00000100, 32'h0, 0, 1'b1);
        check("rsp_wait_busy", {39'd0, busy}, 40'd1);
        check("rsp_wait_tx", {39'd0, tx_valid}, 40'd0);
        do_rsp(3, 32'h11223344, 1'b0);
        send_byte(8'h52);
        send_byte(8'h57);
        collect_tx(5, 40'h11223344_06, 1);
        repeat (3) @(negedge clk);
        check("dropped_rx_idle", {39'd0, busy}, 40'd0);

        // Partial frame waits indefinitely, then completes.
        send_byte(8'h52);
        send_byte(8'h00);
        repeat (200) @(negedge clk);
        check("partial_busy", {39'd0, busy}, 40'd1);
        check("partial_no_cmd", {39'd0, dBus_cmd_valid}, 40'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h80);
        do_cmd(1'b0, 32'h80000000, 32'h0, 0, 1'b0);
        do_rsp(0, 32'hCAFEF00D, 1'b0);
        collect_tx(5, 40'hCAFEF00D_06, 0);

        // Reset mid-frame aborts with no bus cycle.
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h02);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midframe_busy", {39'd0, busy}, 40'd0);
        repeat (3) @(negedge clk);
        check("midframe_cmd", {39'd0, dBus_cmd_valid}, 40'd0);

        // Reset with a read in flight: the late response is discarded.
        send_frame(8'h52, 32'h00000200, 32'h0);
        do_cmd(1'b0, 32'h00000200, 32'h0, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_rsp(1, 32'h99999999, 1'b0);
        repeat (2) @(negedge clk);
        check("inflight_tx", {39'd0, tx_valid}, 40'd0);
        check("inflight_busy", {39'd0, busy}, 40'd0);

        // Normal operation afterwards.
        send_frame(8'h57, 32'h00000010, 32'h76543210);
        do_cmd(1'b1, 32'h00000010, 32'h76543210, 2, 1'b0);
        collect_tx(1, 40'h00000000_06, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
